// File: rtl/hc21_ste_master.sv
// STEbus master cycle controller: turns a CPU access in the STEbus window into a
// full CM/ADRSTB/DATSTB handshake, holding the CPU in wait until it completes.
module hc21_ste_master #(
  parameter int SETUP_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        sysclk,
  input  logic        sysrst,
  input  logic        sel_stebus_n,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic [15:0] cpu_addr,
  input  logic [3:0]  ste_page,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_wait_n,
  output logic [19:0] ste_addr,
  output logic [2:0]  ste_cm,
  output logic        ste_adrstb_n,
  output logic        ste_datstb_n,
  input  logic        ste_datack_n,
  input  logic        ste_tfrerr_n,
  input  logic [7:0]  ste_data_in,
  output logic [7:0]  ste_data_out,
  output logic        ste_data_oe,
  output logic        bus_error,
  input  logic        err_clr
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ASTB, S_WAIT_ACK, S_RELEASE, S_END, S_HOLD
  } state_t;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  ack_sync, err_sync;
  logic        ack, err;
  logic [3:0]  setup_cnt, setup_cnt_nxt;
  logic [7:0]  to_cnt, to_cnt_nxt;
  logic        is_read;
  logic [2:0]  cm_reg;
  logic        start, in_cycle;
  logic        set_err, load_din;
  logic [7:0]  din_val;

  assign ack      = ~ack_sync[1];
  assign err      = ~err_sync[1];
  assign start    = ~sel_stebus_n & ~cpu_mreq_n & (cpu_rd_n ^ cpu_wr_n);
  assign in_cycle = (state == S_SETUP) || (state == S_ASTB) ||
                    (state == S_WAIT_ACK) || (state == S_RELEASE);

  // Strobes, CM and OE decode straight from state so an async reset drops them at once.
  assign ste_adrstb_n = ~((state == S_ASTB) || (state == S_WAIT_ACK) || (state == S_RELEASE));
  assign ste_datstb_n = ~(state == S_WAIT_ACK);
  assign ste_cm       = in_cycle ? cm_reg : 3'b000;
  assign ste_data_oe  = in_cycle & ~is_read;
  assign cpu_wait_n   = ~(in_cycle | ((state == S_IDLE) & start));

  always_comb begin
    state_nxt     = state;
    setup_cnt_nxt = setup_cnt;
    to_cnt_nxt    = to_cnt;
    set_err       = 1'b0;
    load_din      = 1'b0;
    din_val       = 8'hFF;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt     = S_SETUP;
          setup_cnt_nxt = 4'd0;
        end
      end
      S_SETUP: begin
        if (setup_cnt == SETUP_LAST) state_nxt = S_ASTB;
        else setup_cnt_nxt = setup_cnt + 4'd1;
      end
      S_ASTB: begin
        state_nxt  = S_WAIT_ACK;
        to_cnt_nxt = 8'd0;
      end
      // Error outranks acknowledge; timeout only if neither response arrived.
      S_WAIT_ACK: begin
        if (err) begin
          set_err    = 1'b1;
          load_din   = is_read;
          state_nxt  = S_RELEASE;
          to_cnt_nxt = 8'd0;
        end else if (ack) begin
          load_din   = is_read;
          din_val    = ste_data_in;
          state_nxt  = S_RELEASE;
          to_cnt_nxt = 8'd0;
        end else if (to_cnt == TO_LAST) begin
          set_err    = 1'b1;
          load_din   = is_read;
          state_nxt  = S_RELEASE;
          to_cnt_nxt = 8'd0;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
        end
      end
      S_RELEASE: begin
        if (!ack && !err) begin
          state_nxt = S_END;
        end else if (to_cnt == TO_LAST) begin
          set_err   = 1'b1;
          state_nxt = S_END;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
        end
      end
      S_END:  state_nxt = S_HOLD;
      S_HOLD: if (cpu_mreq_n) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      state        <= S_IDLE;
      ack_sync     <= 2'b11;
      err_sync     <= 2'b11;
      setup_cnt    <= 4'd0;
      to_cnt       <= 8'd0;
      is_read      <= 1'b0;
      cm_reg       <= 3'b000;
      ste_addr     <= 20'd0;
      ste_data_out <= 8'd0;
      cpu_din      <= 8'd0;
      bus_error    <= 1'b0;
    end else begin
      state     <= state_nxt;
      ack_sync  <= {ack_sync[0], ste_datack_n};
      err_sync  <= {err_sync[0], ste_tfrerr_n};
      setup_cnt <= setup_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      if (state == S_IDLE && start) begin
        ste_addr <= {ste_page, cpu_addr};
        is_read  <= ~cpu_rd_n;
        cm_reg   <= cpu_rd_n ? 3'b110 : 3'b111;
        if (cpu_rd_n) ste_data_out <= cpu_dout;
      end
      if (load_din) cpu_din <= din_val;
      if (set_err) bus_error <= 1'b1;
      else if (err_clr) bus_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hc21_ste_master.sv
// Self-checking bench for hc21_ste_master: directed test-plan accesses plus
// randomized accesses scored against a transaction-level outcome model.
module tb_hc21_ste_master;

  localparam int T = 16;

  logic        sysclk = 1'b0;
  logic        sysrst = 1'b0;
  logic        sel_stebus_n = 1'b1, cpu_mreq_n = 1'b1, cpu_rd_n = 1'b1, cpu_wr_n = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [3:0]  ste_page = '0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_din;
  logic        cpu_wait_n;
  logic [19:0] ste_addr;
  logic [2:0]  ste_cm;
  logic        ste_adrstb_n, ste_datstb_n;
  logic        ste_datack_n = 1'b1, ste_tfrerr_n = 1'b1;
  logic [7:0]  ste_data_in = '0;
  logic [7:0]  ste_data_out;
  logic        ste_data_oe;
  logic        bus_error;
  logic        err_clr = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  // Transaction-level expectations
  logic       model_err;
  logic [7:0] exp_din;
  logic [7:0] exp_dout;

  hc21_ste_master #(.SETUP_CYCLES(1), .TIMEOUT_CYCLES(T)) dut (
    .sysclk(sysclk), .sysrst(sysrst), .sel_stebus_n(sel_stebus_n),
    .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_addr(cpu_addr), .ste_page(ste_page), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_wait_n(cpu_wait_n), .ste_addr(ste_addr),
    .ste_cm(ste_cm), .ste_adrstb_n(ste_adrstb_n), .ste_datstb_n(ste_datstb_n),
    .ste_datack_n(ste_datack_n), .ste_tfrerr_n(ste_tfrerr_n),
    .ste_data_in(ste_data_in), .ste_data_out(ste_data_out),
    .ste_data_oe(ste_data_oe), .bus_error(bus_error), .err_clr(err_clr)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    sel_stebus_n = 1'b1;
    cpu_mreq_n   = 1'b1;
    cpu_rd_n     = 1'b1;
    cpu_wr_n     = 1'b1;
  endtask

  task automatic pulse_err_clr();
    @(negedge sysclk);
    err_clr = 1'b1;
    @(negedge sysclk);
    err_clr   = 1'b0;
    model_err = 1'b0;
    check("err_clr", bus_error, model_err);
  endtask

  // kind: 0 = DATACK, 1 = TFRERR, 2 = both together, 3 = no response.
  // dly: DATSTB-low cycles the slave waits before driving its response pin.
  task automatic do_access(input bit rd, input logic [15:0] addr, input logic [3:0] page,
                           input logic [7:0] wd, input logic [7:0] rdata,
                           input int kind, input int dly, input bit hold_low);
    int  exp_dat;
    int  dat_cnt;
    int  adr_before;
    bit  done;
    logic [2:0] exp_cm;

    pulse_err_clr();
    exp_cm  = rd ? 3'b111 : 3'b110;
    exp_dat = (kind == 3) ? T : dly + 3;
    if (!rd) exp_dout = wd;
    if (rd) exp_din = (kind == 0) ? rdata : 8'hFF;
    if (kind != 0) model_err = 1'b1;

    sel_stebus_n = 1'b0;
    cpu_mreq_n   = 1'b0;
    cpu_rd_n     = ~rd;
    cpu_wr_n     = rd;
    cpu_addr     = addr;
    ste_page     = page;
    cpu_dout     = rd ? 8'($urandom) : wd;
    ste_data_in  = rdata;
    #1 check("wait_on_decode", cpu_wait_n, 1'b0);

    dat_cnt = 0; adr_before = 0; done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge sysclk);
      if (!ste_datstb_n) begin
        dat_cnt++;
        if (dat_cnt == 1) begin
          check("addr", ste_addr, {page, addr});
          check("cm", ste_cm, exp_cm);
          check("oe", ste_data_oe, !rd);
          if (!rd) check("data_out", ste_data_out, exp_dout);
        end
        if (dat_cnt == dly + 1 && kind != 3) begin
          ste_datack_n = !(kind == 0 || kind == 2);
          ste_tfrerr_n = !(kind == 1 || kind == 2);
        end
      end else begin
        if (dat_cnt > 0) begin
          ste_datack_n = 1'b1;
          ste_tfrerr_n = 1'b1;
        end else if (!ste_adrstb_n) begin
          adr_before++;
        end
      end
      if (cpu_wait_n === 1'b1) done = 1'b1;
    end
    check("access_done", done, 1'b1);
    check("datstb_cycles", dat_cnt, exp_dat);
    check("adrstb_lead", adr_before, 1);
    check("end_cm", ste_cm, 3'b000);
    check("end_oe", ste_data_oe, 1'b0);
    check("end_adrstb", ste_adrstb_n, 1'b1);
    check("end_addr", ste_addr, {page, addr});
    check("end_data_out", ste_data_out, exp_dout);
    check("bus_error", bus_error, model_err);
    check("cpu_din", cpu_din, exp_din);

    if (hold_low) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge sysclk);
        check("hold_no_restart", {ste_adrstb_n, cpu_wait_n}, 2'b11);
      end
    end
    idle_bus();
    @(negedge sysclk);
    @(negedge sysclk);
  endtask

  initial begin
    model_err = 1'b0; exp_din = 8'h00; exp_dout = 8'h00;
    #1 sysrst = 1'b1;
    #2;
    check("rst_wait", cpu_wait_n, 1'b1);
    check("rst_strobes", {ste_adrstb_n, ste_datstb_n}, 2'b11);
    check("rst_cm", ste_cm, 3'b000);
    check("rst_oe", ste_data_oe, 1'b0);
    check("rst_addr", ste_addr, 20'h0);
    check("rst_data_out", ste_data_out, 8'h00);
    check("rst_din", cpu_din, 8'h00);
    check("rst_bus_error", bus_error, 1'b0);
    @(negedge sysclk);
    @(negedge sysclk);
    sysrst = 1'b0;

    $display("[TB] write / read / timeout / error precedence");
    do_access(1'b0, 16'h4123, 4'h2, 8'h5A, 8'h00, 0, 2, 1'b0);
    do_access(1'b1, 16'hBFFF, 4'h0, 8'h00, 8'hC3, 0, 0, 1'b0);
    do_access(1'b1, 16'h8000, 4'h1, 8'h00, 8'h77, 3, 0, 1'b0);
    pulse_err_clr();
    do_access(1'b1, 16'h6000, 4'h3, 8'h00, 8'h12, 2, 1, 1'b1);

    $display("[TB] no select");
    @(negedge sysclk);
    sel_stebus_n = 1'b1; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sysclk);
      check("nosel", {ste_adrstb_n, ste_datstb_n, cpu_wait_n}, 3'b111);
    end
    idle_bus();

    $display("[TB] randomized accesses");
    for (int n = 0; n < 20; n++) begin
      logic [15:0] a;
      a = 16'h4000 + 16'($urandom_range(0, 16'h7FFF));
      do_access(1'($urandom), a, 4'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, T - 3)), 1'($urandom));
    end

    $display("[TB] reset mid-cycle");
    @(negedge sysclk);
    sel_stebus_n = 1'b0; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b1; cpu_wr_n = 1'b0;
    cpu_dout = 8'hA5;
    for (int i = 0; i < 20 && ste_datstb_n; i++) @(negedge sysclk);
    check("pre_rst_datstb", ste_datstb_n, 1'b0);
    #1;
    sysrst = 1'b1;
    idle_bus();
    #1;
    check("midrst_strobes", {ste_adrstb_n, ste_datstb_n}, 2'b11);
    check("midrst_oe", ste_data_oe, 1'b0);
    check("midrst_wait", cpu_wait_n, 1'b1);
    @(negedge sysclk);
    sysrst = 1'b0;
    model_err = 1'b0; exp_din = 8'h00; exp_dout = 8'h00;
    check("midrst_bus_error", bus_error, model_err);
    check("midrst_data_out", ste_data_out, exp_dout);
    do_access(1'b1, 16'h4001, 4'hF, 8'h00, 8'h3C, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hc21_ste_master.md
# hc21_ste_master

STEbus master cycle controller for the HC21-STE CPU card. It turns a CPU memory access in the STEbus window (0x4000–0xBFFF, flagged by the address decoder's `sel_stebus_n`) into a complete STEbus handshake: CM, ADRSTB, DATSTB, then wait for DATACK or TFRERR. The CPU is held in wait until the bus cycle finishes. Slave non-response is caught by a timeout, and all errors are reported through a sticky flag.

## Interface
- `SETUP_CYCLES`, default 1: cycles that address, CM and write data are driven before ADRSTB asserts (1–15).
- `TIMEOUT_CYCLES`, default 255: maximum cycles in WAIT_ACK, and separately in RELEASE, before the cycle is abandoned (1–255).
- `sysclk`, in, 1: system clock; all logic is on the rising edge.
- `sysrst`, in, 1: reset, asynchronous and active-high.
- `sel_stebus_n`, in, 1: registered STEbus-window select from the decoder.
- `cpu_mreq_n`, `cpu_rd_n`, `cpu_wr_n`, in, 1 each: CPU memory strobes.
- `cpu_addr`, in, 16: CPU address.
- `ste_page`, in, 4: upper STEbus address bits A19:A16.
- `cpu_dout`, in, 8: CPU write data.
- `cpu_din`, out, 8: latched read data returned to the CPU.
- `cpu_wait_n`, out, 1: CPU wait request, active low.
- `ste_addr`, out, 20: STEbus address, `{ste_page, cpu_addr}`.
- `ste_cm`, out, 3: command modifier. 3'b111 = memory read, 3'b110 = memory write, 3'b000 = idle.
- `ste_adrstb_n`, `ste_datstb_n`, out, 1 each: address and data strobes.
- `ste_datack_n`, `ste_tfrerr_n`, in, 1 each: asynchronous slave responses.
- `ste_data_in`, in, 8: STEbus data in.
- `ste_data_out`, out, 8: STEbus data out.
- `ste_data_oe`, out, 1: STEbus data output enable.
- `bus_error`, out, 1: sticky error flag.
- `err_clr`, in, 1: clears `bus_error`.

## Operation
- **Start condition** (evaluated in IDLE only): `sel_stebus_n`=0, `cpu_mreq_n`=0, and exactly one of `cpu_rd_n`/`cpu_wr_n` is 0.
- **Response synchronisers:** `ste_datack_n` and `ste_tfrerr_n` each pass through a 2-flop synchroniser. The FSM sees only the synchronised values (`ack`, `err`).
- **IDLE → SETUP** on start:
  - `ste_addr`, `ste_cm` and the read/write direction are registered.
  - For writes, `ste_data_out` = `cpu_dout` and `ste_data_oe` = 1.
- **SETUP**: lasts `SETUP_CYCLES` cycles, then → ASTB.
- **ASTB**: `ste_adrstb_n` = 0 for one cycle, then → WAIT_ACK.
- **WAIT_ACK**:
  - `ste_datstb_n` = 0. The timeout counter starts at 0 and increments each cycle.
  - `err` → `bus_error` set; reads load `cpu_din` = 8'hFF; → RELEASE.
  - else `ack` → reads load `cpu_din` = `ste_data_in`; → RELEASE.
  - else counter = `TIMEOUT_CYCLES` − 1 → `bus_error` set; reads load `cpu_din` = 8'hFF; → RELEASE.
  - `err` and `ack` together: error path wins.
- **RELEASE**:
  - `ste_datstb_n` = 1, `ste_adrstb_n` still 0, counter restarts.
  - `ack` = 0 and `err` = 0 → END.
  - Counter reaching `TIMEOUT_CYCLES` − 1 → END with `bus_error` set.
- **END** (one cycle): `ste_adrstb_n` = 1, `ste_data_oe` = 0, `ste_cm` = 000, `cpu_wait_n` = 1, → HOLD.
- **HOLD**: → IDLE when `cpu_mreq_n` = 1. This prevents the same CPU access from starting a second cycle.
- **`bus_error`**: set only by the events above and cleared by `err_clr`. Set and clear in the same cycle: set wins.
- **`cpu_din`**: holds its value until the next read completes.

## Timing
- **Reset values:**
  - FSM in IDLE.
  - `cpu_wait_n`, `ste_adrstb_n`, `ste_datstb_n` = 1.
  - `ste_cm` = 000, `ste_data_oe` = 0.
  - `ste_addr`, `ste_data_out`, `cpu_din` = 0.
  - `bus_error` = 0; synchronisers = 1.
- **Reset mid-cycle:** strobes deassert and `ste_data_oe` drops immediately (asynchronous). The bus is released with no END/HOLD sequence.
- **`cpu_wait_n`:**
  - Combinationally 0 when in IDLE with the start condition true, or in any of SETUP/ASTB/WAIT_ACK/RELEASE.
  - 1 in END, HOLD, and IDLE without start. This guarantees wait is asserted in the same cycle the access is decoded.
- **Minimum cycle**, with `SETUP_CYCLES`=1 and slave ack on the pin in the cycle DATSTB asserts:
  - Start seen at edge 0; SETUP from edge 1; ASTB at edge 2; WAIT_ACK at edge 3.
  - `ack` is visible 2 edges later; RELEASE at edge 6.
  - After the slave releases, 2 more edges to see `ack` low; END, then `cpu_wait_n` high.
- **`ste_addr`/`ste_cm`/write data:** stable from SETUP through END inclusive.
- **Response latency:** 2 synchroniser cycles plus 1 FSM cycle after the slave's pin edge.

## Test plan
- **Write:** `cpu_addr`=16'h4123, `ste_page`=4'h2, `cpu_dout`=8'h5A; slave acks 2 cycles after DATSTB → `ste_addr`=20'h24123, `ste_cm`=110, `ste_data_out`=5A with oe=1 throughout. ADRSTB precedes DATSTB by 1 cycle. `cpu_wait_n` returns to 1; `bus_error`=0.
- **Read:** address 16'hBFFF, slave drives 8'hC3 with DATACK → `ste_cm`=111, `ste_data_oe`=0, `cpu_din`=C3 when `cpu_wait_n` rises.
- **Timeout:** read with no DATACK, `TIMEOUT_CYCLES`=16 → DATSTB asserted for exactly 16 cycles; `bus_error`=1, `cpu_din`=FF. Then `err_clr` pulse → `bus_error`=0.
- **Error precedence:** `ste_tfrerr_n` and `ste_datack_n` fall together on a read → `bus_error`=1, `cpu_din`=FF.
- **No select:** `sel_stebus_n`=1 with `cpu_mreq_n`=0 → no strobes, `cpu_wait_n` stays 1. Also: holding `cpu_mreq_n` low after END starts no second cycle.
- **Reset mid-cycle:** assert `sysrst` in WAIT_ACK → strobes=1, oe=0, `cpu_wait_n`=1 before the next clock edge.
